// File: rtl/mac_pkg.sv
// Shared types and helpers for the streaming multiply-accumulate engine.
// Saturation limits are returned in a wide signed type so any OUT_W/ACC_W pair compares cleanly.
package mac_pkg;

    localparam int WIDE_W = 128;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } stage_ctrl_t;

    function automatic wide_t sat_max(input int out_w, input bit is_signed);
        if (is_signed)
            return (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
        else
            return (wide_t'(1) <<< out_w) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int out_w, input bit is_signed);
        if (is_signed)
            return -(wide_t'(1) <<< (out_w - 1));
        else
            return '0;
    endfunction

endpackage

// File: rtl/mac_round_sat.sv
// Combinational round-half-up, right shift and optional clamp of an accumulator value.
// Works in a wide signed domain so the rounding add can never wrap.
module mac_round_sat
    import mac_pkg::*;
#(
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 15,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 1
) (
    input  logic [ACC_W-1:0] acc_in,
    output logic [OUT_W-1:0] data_out,
    output logic             sat_out
);

    localparam wide_t HALF  = (OUT_SHIFT > 0) ? (wide_t'(1) <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
    localparam wide_t MAX_V = sat_max(OUT_W, SIGNED != 0);
    localparam wide_t MIN_V = sat_min(OUT_W, SIGNED != 0);

    wide_t ext;
    wide_t shifted;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        if (SIGNED != 0)
            ext = wide_t'(signed'(acc_in));
        else
            ext = wide_t'(acc_in);

        shifted  = (ext + HALF) >>> OUT_SHIFT;
        data_out = shifted[OUT_W-1:0];
        sat_out  = 1'b0;

        if (SATURATE != 0) begin
            if (shifted > MAX_V) begin
                data_out = MAX_V[OUT_W-1:0];
                sat_out  = 1'b1;
            end else if (shifted < MIN_V) begin
                data_out = MIN_V[OUT_W-1:0];
                sat_out  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_stream_engine.sv
// Pipelined multiply-accumulate for framed dot products with valid/ready on both sides.
// Stages: S1 operands, S2 product, S3 accumulator, then the rounded/saturated output register.
module mac_stream_engine
    import mac_pkg::*;
#(
    parameter int A_W       = 16,
    parameter int B_W       = 16,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 15,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic [ACC_W-1:0] out_acc
);

    localparam int PROD_W = A_W + B_W;

    logic              en;
    stage_ctrl_t       ctrl1, ctrl2, ctrl3;
    logic [A_W-1:0]    a1;
    logic [B_W-1:0]    b1;
    logic [PROD_W-1:0] prod_d, prod2;
    logic [ACC_W-1:0]  prod_ext, acc, acc_next;
    logic [OUT_W-1:0]  conv_data;
    logic              conv_sat;

    // A held result freezes the whole pipeline, so nothing in flight can be overwritten.
    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;

    always_comb begin
        if (SIGNED != 0) begin
            prod_d   = PROD_W'(signed'(a1)) * PROD_W'(signed'(b1));
            prod_ext = ACC_W'(signed'(prod2));
        end else begin
            prod_d   = PROD_W'(a1) * PROD_W'(b1);
            prod_ext = ACC_W'(prod2);
        end
        acc_next = ctrl2.first ? prod_ext : acc + prod_ext;
    end

    mac_round_sat #(
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W),
        .OUT_SHIFT(OUT_SHIFT),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_round_sat (
        .acc_in  (acc),
        .data_out(conv_data),
        .sat_out (conv_sat)
    );

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl1     <= '0;
            ctrl2     <= '0;
            ctrl3     <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_acc   <= '0;
        end else if (en) begin
            ctrl1     <= stage_ctrl_t'{valid: in_valid, first: in_first, last: in_last};
            ctrl2     <= ctrl1;
            ctrl3     <= ctrl2;
            if (ctrl2.valid)
                acc <= acc_next;
            out_valid <= ctrl3.valid & ctrl3.last;
            if (ctrl3.valid && ctrl3.last) begin
                out_data <= conv_data;
                out_sat  <= conv_sat;
                out_acc  <= acc;
            end
        end
    end

    // NOTE: operand and product registers carry no reset; the stage valid bits decide whether they matter.
    always_ff @(posedge clk) begin
        if (en) begin
            a1    <= in_a;
            b1    <= in_b;
            prod2 <= prod_d;
        end
    end

endmodule

// File: tb/tb_mac_stream_engine.sv
// Scoreboard bench: the driver feeds a frame-level arithmetic model, the monitor checks every presented result.
module tb_mac_stream_engine;

    localparam int A_W = 16, B_W = 16, ACC_W = 40, OUT_W = 16, OUT_SHIFT = 15;

    logic             clk;
    logic             rst_n;
    logic             in_valid, in_ready, in_first, in_last;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             out_valid, out_ready, out_sat;
    logic [OUT_W-1:0] out_data;
    logic [ACC_W-1:0] out_acc;

    mac_stream_engine #(
        .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .OUT_SHIFT(OUT_SHIFT), .SIGNED(1), .SATURATE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_acc(out_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             sat;
        logic [ACC_W-1:0] acc;
    } exp_t;

    exp_t   sb[$];
    longint model_acc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     n_out = 0;
    bit     rdy_rand = 1'b0;
    bit     rdy_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Two's-complement wrap of the running sum to ACC_W bits.
    function automatic longint wrap_acc(input longint v);
        longint m;
        m = v & ((longint'(1) << ACC_W) - 1);
        if (m[ACC_W-1])
            m = m - (longint'(1) << ACC_W);
        return m;
    endfunction

    function automatic exp_t convert(input longint acc);
        exp_t   e;
        longint q;
        longint hi = (longint'(1) << (OUT_W - 1)) - 1;
        longint lo = -(longint'(1) << (OUT_W - 1));
        q = (acc + ((OUT_SHIFT > 0) ? (longint'(1) << (OUT_SHIFT - 1)) : 0)) >>> OUT_SHIFT;
        e.sat = 1'b0;
        if (q > hi) begin
            q = hi;
            e.sat = 1'b1;
        end else if (q < lo) begin
            q = lo;
            e.sat = 1'b1;
        end
        e.data = q[OUT_W-1:0];
        e.acc  = acc[ACC_W-1:0];
        return e;
    endfunction

    task automatic model_beat(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input bit first, input bit last);
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        model_acc = wrap_acc(first ? p : model_acc + p);
        if (last)
            sb.push_back(convert(model_acc));
    endtask

    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input bit first, input bit last);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_first = first;
        in_last  = last;
        #1;
        while (!in_ready) begin
            if (waited > 300) begin
                check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
                in_valid = 1'b0;
                return;
            end
            waited++;
            @(negedge clk);
            #1;
        end
        model_beat(a, b, first, last);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
        repeat (5) @(posedge clk);
    endtask

    always @(negedge clk)
        out_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_force;

    // Monitor: compare the head of the scoreboard whenever a result is presented; pop when consumed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = sb[0];
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_sat", 64'(out_sat), 64'(e.sat));
                    check("out_acc", 64'(out_acc), 64'(e.acc));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    initial begin
        int start_out;
        logic [A_W-1:0] ra;
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_out_acc", 64'(out_acc), 64'd0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        // Two-beat frame plus latency: result must appear exactly after the third edge past the last beat.
        send(16'd5, 16'd3, 1'b1, 1'b0);
        send(16'd10, 16'd1, 1'b0, 1'b1);
        idle();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 check("latency_not_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1 check("latency_on_time", 64'(out_valid), 64'd1);
        drain();

        // Signed single-beat frame, rounding boundary, positive and negative saturation.
        send(16'hFFFC, 16'd7, 1'b1, 1'b1);
        send(16'h4000, 16'h0001, 1'b1, 1'b1);
        send(16'h3FFF, 16'h0001, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(16'h7FFF, 16'h7FFF, i == 0, i == 3);
        for (int i = 0; i < 4; i++) send(16'h8001, 16'h7FFF, i == 0, i == 3);
        idle();
        drain();

        // Backpressure: three results queued behind a stalled consumer.
        rdy_force = 1'b0;
        @(negedge clk);
        start_out = n_out;
        send(16'd1, 16'd2, 1'b1, 1'b1);
        send(16'd1, 16'd3, 1'b1, 1'b1);
        send(16'd1, 16'd4, 1'b1, 1'b1);
        idle();
        repeat (6) @(negedge clk);
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid_high", 64'(out_valid), 64'd1);
        rdy_force = 1'b1;
        drain();
        check("bp_result_count", 64'(n_out - start_out), 64'd3);

        // Reset mid-frame discards the partial sum; the next frame yields one result.
        send(16'd3, 16'd3, 1'b1, 1'b0);
        send(16'd2, 16'd2, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        model_acc = 0;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        start_out = n_out;
        send(16'd6, 16'd7, 1'b1, 1'b1);
        idle();
        drain();
        check("midrst_result_count", 64'(n_out - start_out), 64'd1);

        // Randomised frames with random gaps and random downstream stalls.
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(3) == 0) ? 16'h7FFF - 16'($urandom_range(15)) : 16'($urandom);
            send(ra, 16'($urandom), $urandom_range(5) == 0, $urandom_range(4) == 0);
            if ($urandom_range(3) == 0)
                idle();
        end
        idle();
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
